digit_serial_subtractor: RTL and testbench
==========================================

# digit_serial_subtractor

Multi-cycle subtractor, the inverse operation of the team's combinational Ling adder. It computes a − b − bin over WIDTH bits, DIGIT bits per clock. The borrow is registered between digits, so the critical path is one DIGIT-wide slice. Operands are accepted and results delivered through valid/ready handshakes, so the block sits between an operand producer and a result consumer in the arithmetic datapath.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT (elaboration error otherwise)
- DIGIT, 4, bits processed per cycle; NDIG = WIDTH/DIGIT

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  minuend (unsigned, or two's complement for ovf)
- b  in  WIDTH  subtrahend
- bin  in  1  borrow-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- diff  out  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  out  1  unsigned borrow-out: 1 iff a < b + bin
- ovf  out  1  signed overflow: a[MSB]≠b[MSB] and diff[MSB]≠a[MSB]

## Operation
- FSM with three states:
  - IDLE: in_ready=1. An accept occurs when in_valid=1 at the clock edge. On accept: latch a, b, bin; set digit counter to 0; go to RUN.
  - RUN: on each edge, slice k=count computes a[k]−b[k]−borrow, writes diff digit k, and registers the new borrow (bin for k=0). When count=NDIG−1, go to DONE; otherwise count+1.
  - DONE: out_valid=1; diff, bout and ovf are stable. When out_ready=1 at an edge, go to IDLE.
- bout is the borrow out of the final digit. ovf is computed from the latched a[MSB], the latched b[MSB] and the final diff[MSB].
- in_ready = (state==IDLE). There is no overlap: operands are never accepted in RUN or DONE, and in_valid in those states is ignored.
- Ports a, b and bin are sampled only at the accept edge. Later changes have no effect on the result.
- Reset: asynchronous.
  - state=IDLE, counter=0, diff=0, bout=0, ovf=0, out_valid=0, in_ready=1.
  - Reset mid-operation (RUN or DONE) discards the in-flight operation and produces no partial result.
- diff/bout/ovf hold their last values outside DONE. Consumers qualify them with out_valid only.

## Timing
- Accept at edge N. Digits are computed at edges N+1 … N+NDIG. out_valid rises after edge N+NDIG; latency is NDIG cycles (4 at defaults).
- out_valid stays high until the edge where out_ready=1. in_ready rises after that edge.
- Minimum issue interval is NDIG+2 cycles (accept edge, NDIG RUN edges, one output edge).
- out_ready held high in advance gives a one-cycle out_valid pulse.

## Structure
- Package digit_serial_pkg:
  - state enum {IDLE, RUN, DONE}
  - function computing ovf from the two operand MSBs and the result MSB
- Sub-module ling_sub_digit (combinational): DIGIT-bit subtract slice with inputs x, y, borrow_in and outputs d, borrow_out. It uses Ling-style generate/propagate on x and ~y, with carry-in = ~borrow_in.
- Top level contains the FSM, counter, operand/result registers and a digit mux.

## Test plan
- a=0x1234, b=0x0234, bin=0, out_ready=1 → diff=0x1000, bout=0, ovf=0; out_valid exactly 4 cycles after accept.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0 (borrow ripples through all 4 digits).
- a=0x8000, b=0x0001, bin=0 → diff=0x7FFF, bout=0, ovf=1; and a=0x7FFF, b=0xFFFF → diff=0x8000, bout=1, ovf=1.
- a=0x00FF, b=0x00FF, bin=1 → diff=0xFFFF, bout=1, ovf=0.
- Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid=1 and changing a/b.
  - diff/bout/ovf stay stable; in_ready=0; no new operation is accepted.
  - After out_ready=1, the next accept uses the operands present at that new accept edge.
- Reset in the second RUN cycle → out_valid=0 and in_ready=1 immediately, with no result delivered. After release, a=0xFFFF, b=0x0001 → diff=0xFFFE, bout=0.

Source files
------------

// File: rtl/digit_serial_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// Holds the control-state encoding and the signed-overflow rule.
package digit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed overflow of a - b: operand signs differ and the result sign differs from a
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/ling_sub_digit.sv
// One DIGIT-wide subtract slice: x - y - borrow_in, built as x + ~y + ~borrow_in
// with Ling-style pseudo-carry formation across the slice.
module ling_sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             borrow_in,
  output logic [DIGIT-1:0] d,
  output logic             borrow_out
);

  logic [DIGIT-1:0] yn_s;
  logic [DIGIT-1:0] g_s;
  logic [DIGIT-1:0] t_s;
  logic [DIGIT-1:0] hs_s;
  logic             h_s;
  logic             carry_s;

  assign yn_s = ~y;
  assign g_s  = x & yn_s;
  assign t_s  = x | yn_s;
  assign hs_s = x ^ yn_s;

  // Ling pseudo-carry h = g | c_in; the real carry out of a bit is t & h
  always_comb begin
    d       = '0;
    h_s     = 1'b0;
    carry_s = ~borrow_in;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]    = hs_s[i] ^ carry_s;
      h_s     = g_s[i] | carry_s;
      carry_s = t_s[i] & h_s;
    end
    borrow_out = ~carry_s;
  end

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle a - b - bin, one DIGIT-wide slice per clock with the borrow
// registered between digits; operands and result use valid/ready handshakes.
module digit_serial_subtractor
  import digit_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_width_check
    $error("digit_serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] x_s;
  logic [DIGIT-1:0] y_s;
  logic [DIGIT-1:0] d_s;
  logic             bo_s;

  assign x_s = a_q[count_q*DIGIT +: DIGIT];
  assign y_s = b_q[count_q*DIGIT +: DIGIT];

  ling_sub_digit #(.DIGIT(DIGIT)) u_slice (
    .x          (x_s),
    .y          (y_s),
    .borrow_in  (borrow_q),
    .d          (d_s),
    .borrow_out (bo_s)
  );

  // Next-state, operand capture and per-digit result update
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          count_d  = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        diff_d[count_q*DIGIT +: DIGIT] = d_s;
        borrow_d = bo_s;
        if (count_q == LAST) begin
          // The last slice carries diff[MSB], so overflow is resolved here too
          bout_d  = bo_s;
          ovf_d   = ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1], d_s[DIGIT-1]);
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, operand and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Self-checking bench: directed corner cases, backpressure, mid-run reset and
// random operands against an arithmetic reference model.
module tb_digit_serial_subtractor;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  digit_serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: wide unsigned subtraction; borrow is the sign bit of the widened result
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin,
                       output logic [WIDTH-1:0] ed, output logic eb, output logic eo);
    logic [WIDTH:0] r;
    r  = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
    ed = r[WIDTH-1:0];
    eb = r[WIDTH];
    eo = (ma[WIDTH-1] != mb[WIDTH-1]) && (ed[WIDTH-1] != ma[WIDTH-1]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge (waits for in_ready), then scramble the ports
  task automatic start_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic obin);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
  endtask

  // Wait for out_valid (bounded), check latency from accept and the result
  task automatic wait_result(input string tag, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                             input logic obin);
    logic [WIDTH-1:0] ed;
    logic eb, eo;
    int lat;
    model(oa, ob, obin, ed, eb, eo);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(NDIG));
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
    check({tag, "_ovf"},  32'(ovf),  32'(eo));
  endtask

  task automatic full_op(input string tag, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                         input logic obin);
    start_op(oa, ob, obin);
    wait_result(tag, oa, ob, obin);
    tick();
  endtask

  initial begin
    logic [WIDTH-1:0] hold_d, ra, rb, na, nb;
    logic hold_b, hold_o, rbin;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    #23;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff",      32'(diff),      32'd0);
    check("rst_bout",      32'(bout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    rst = 1'b0;
    tick();

    // Directed corners with out_ready held high (one-cycle out_valid pulse)
    start_op(16'h1234, 16'h0234, 1'b0);
    wait_result("t1", 16'h1234, 16'h0234, 1'b0);
    check("t1_diff_const", 32'(diff), 32'h1000);
    tick();
    check("pulse_out_valid", 32'(out_valid), 32'd0);
    check("pulse_in_ready",  32'(in_ready),  32'd1);

    full_op("ripple",  16'h0000, 16'h0001, 1'b0);
    full_op("ovf_neg", 16'h8000, 16'h0001, 1'b0);
    full_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0);
    full_op("bin_eq",  16'h00FF, 16'h00FF, 1'b1);

    // Backpressure: result held, new operands refused while in DONE
    out_ready = 1'b0;
    start_op(16'hA5A5, 16'h5A5A, 1'b1);
    wait_result("bp", 16'hA5A5, 16'h5A5A, 1'b1);
    hold_d = diff; hold_b = bout; hold_o = ovf;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_diff_hold", 32'(diff),      32'(hold_d));
      check("bp_bout_hold", 32'(bout),      32'(hold_b));
      check("bp_ovf_hold",  32'(ovf),       32'(hold_o));
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    na = 16'h4321; nb = 16'h1111;
    full_op("bp_next", na, nb, 1'b0);

    // Reset during the second RUN cycle discards the operation
    start_op(16'h1111, 16'h2222, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    tick();
    tick();
    #2;
    rst = 1'b0;
    for (int i = 0; i < NDIG + 2; i++) begin
      tick();
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end
    full_op("after_rst", 16'hFFFF, 16'h0001, 1'b0);
    check("after_rst_diff_const", 32'(diff), 32'hFFFE);

    // Random operands, random consumer stalls
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom);
      if (n % 4 == 3) begin
        ra = {1'b1, ra[WIDTH-2:0]};
        rb = {1'b0, rb[WIDTH-2:0]};
      end else begin
        ra = ra;
      end
      out_ready = 1'($urandom);
      start_op(ra, rb, rbin);
      wait_result("rand", ra, rb, rbin);
      for (int s = 0; s < 3 && !out_ready; s++) begin
        tick();
        check("rand_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      check("rand_released", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
